// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle control path: FSM states, opcodes,
// datapath select values and the bundled control-output struct.
package multicycle_pkg;

  // FSM state encodings (4-bit, also exported on the debug port)
  localparam logic [3:0] S_RST    = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_EXE_C  = 4'd3;
  localparam logic [3:0] S_WB_C   = 4'd4;
  localparam logic [3:0] S_EXE_I  = 4'd5;
  localparam logic [3:0] S_WB_I   = 4'd6;
  localparam logic [3:0] S_MEM_RD = 4'd7;
  localparam logic [3:0] S_WB_LD  = 4'd8;
  localparam logic [3:0] S_MEM_WR = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;
  localparam logic [3:0] S_BRZ    = 4'd11;

  // Opcodes (IR[15:12]); the ALU-control decoder shares these
  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_JUMP  = 4'b0010;
  localparam logic [3:0] OP_BRZ   = 4'b0100;
  localparam logic [3:0] OP_TYPEC = 4'b1000;
  localparam logic [3:0] OP_ADDI  = 4'b1100;
  localparam logic [3:0] OP_SUBI  = 4'b1101;
  localparam logic [3:0] OP_ANDI  = 4'b1110;
  localparam logic [3:0] OP_ORI   = 4'b1111;

  // PC source select
  localparam logic [1:0] PCSRC_INC    = 2'b00;
  localparam logic [1:0] PCSRC_JUMP   = 2'b01;
  localparam logic [1:0] PCSRC_BRANCH = 2'b10;

  // Register-file write selects
  localparam logic REGDST_R0    = 1'b0;
  localparam logic REGDST_RI    = 1'b1;
  localparam logic MEMTOREG_ALU = 1'b0;
  localparam logic MEMTOREG_MDR = 1'b1;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       mdr_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ab_write;
    logic       alu_src_b;
    logic       alu_out_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Shared memory-port handshake: request/address select out, ready back in.
interface multicycle_control_fsm_if;
  logic MemRead;
  logic MemWrite;
  logic IorD;
  logic mem_ready;

  modport master (output MemRead, output MemWrite, output IorD, input mem_ready);
  modport slave  (input MemRead, input MemWrite, input IorD, output mem_ready);
endinterface

// File: rtl/multicycle_control_fsm_output_decode.sv
// Pure combinational map from FSM state (plus ready/zero/move-to qualifiers)
// to every datapath enable and select. Anything not driven in a state is 0.
module mc_output_decode
  import multicycle_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  input  logic       Zero,
  input  logic       isMoveTo,
  output ctrl_t      ctrl
);

  // Per-state control outputs; unknown encodings fall through to all-zero
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b0;
        // IR and PC only load on the cycle the read actually completes
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = PCSRC_INC;
        end
      end
      S_DECODE: ctrl.ab_write = 1'b1;
      S_EXE_C: begin
        ctrl.alu_src_b     = 1'b0;
        ctrl.alu_out_write = 1'b1;
      end
      S_WB_C: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = MEMTOREG_ALU;
        ctrl.reg_dst    = isMoveTo ? REGDST_RI : REGDST_R0;
      end
      S_EXE_I: begin
        ctrl.alu_src_b     = 1'b1;
        ctrl.alu_out_write = 1'b1;
      end
      S_WB_I: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_R0;
        ctrl.mem_to_reg = MEMTOREG_ALU;
      end
      S_MEM_RD: begin
        ctrl.mem_read  = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.mdr_write = mem_ready;
      end
      S_WB_LD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_R0;
        ctrl.mem_to_reg = MEMTOREG_MDR;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
      end
      S_BRZ: begin
        ctrl.pc_src   = PCSRC_BRANCH;
        ctrl.pc_write = Zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main multicycle control FSM: state register plus next-state logic.
// Outputs are decoded combinationally from the state so an asynchronous
// reset kills every request (including an in-flight write) immediately.
module multicycle_control_fsm
  import multicycle_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [3:0]                     Op,
  input  logic                           isMoveTo,
  input  logic                           isNop,
  input  logic                           Zero,
  multicycle_control_fsm_if.master       mem,
  output logic                           IRWrite,
  output logic                           MDRWrite,
  output logic                           PCWrite,
  output logic [1:0]                     PCSrc,
  output logic                           ABWrite,
  output logic                           ALUSrcB,
  output logic                           AluOutWrite,
  output logic                           RegWrite,
  output logic                           RegDst,
  output logic                           MemToReg,
  output logic                           illegal_op,
  output logic [3:0]                     state
);

  logic [3:0] state_q, state_d;
  ctrl_t      ctrl;

  // Next-state selection; opcode dispatch happens only in DECODE
  always_comb begin
    state_d    = state_q;
    illegal_op = 1'b0;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  if (mem.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_TYPEC:                            state_d = isNop ? S_FETCH : S_EXE_C;
          OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI:   state_d = S_EXE_I;
          OP_LOAD:                             state_d = S_MEM_RD;
          OP_STORE:                            state_d = S_MEM_WR;
          OP_JUMP:                             state_d = S_JUMP;
          OP_BRZ:                              state_d = S_BRZ;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_EXE_C:  state_d = S_WB_C;
      S_EXE_I:  state_d = S_WB_I;
      S_MEM_RD: if (mem.mem_ready) state_d = S_WB_LD;
      S_MEM_WR: if (mem.mem_ready) state_d = S_FETCH;
      default:  state_d = S_FETCH;  // write-backs, JUMP, BRZ, unreachable codes
    endcase
  end

  // State register, the only storage in the block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RST;
    else        state_q <= state_d;
  end

  mc_output_decode u_out (
    .state     (state_q),
    .mem_ready (mem.mem_ready),
    .Zero      (Zero),
    .isMoveTo  (isMoveTo),
    .ctrl      (ctrl)
  );

  assign mem.MemRead  = ctrl.mem_read;
  assign mem.MemWrite = ctrl.mem_write;
  assign mem.IorD     = ctrl.iord;
  assign IRWrite      = ctrl.ir_write;
  assign MDRWrite     = ctrl.mdr_write;
  assign PCWrite      = ctrl.pc_write;
  assign PCSrc        = ctrl.pc_src;
  assign ABWrite      = ctrl.ab_write;
  assign ALUSrcB      = ctrl.alu_src_b;
  assign AluOutWrite  = ctrl.alu_out_write;
  assign RegWrite     = ctrl.reg_write;
  assign RegDst       = ctrl.reg_dst;
  assign MemToReg     = ctrl.mem_to_reg;
  assign state        = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle vectors of inputs and
// hand-derived state/output values, one task per scenario.
module tb_multicycle_control_fsm;
  import multicycle_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] Op;
  logic       isMoveTo, isNop, Zero;
  logic       IRWrite, MDRWrite, PCWrite, ABWrite, ALUSrcB, AluOutWrite;
  logic       RegWrite, RegDst, MemToReg, illegal_op;
  logic [1:0] PCSrc;
  logic [3:0] state;
  int         checks = 0;
  int         errors = 0;

  multicycle_control_fsm_if mem_if ();

  multicycle_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .isMoveTo(isMoveTo), .isNop(isNop),
    .Zero(Zero), .mem(mem_if), .IRWrite(IRWrite), .MDRWrite(MDRWrite),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .ABWrite(ABWrite), .ALUSrcB(ALUSrcB),
    .AluOutWrite(AluOutWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemToReg(MemToReg), .illegal_op(illegal_op), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs, MSB first:
  // MemRead MemWrite IorD IRWrite MDRWrite PCWrite PCSrc[1:0] ABWrite ALUSrcB
  // AluOutWrite RegWrite RegDst MemToReg illegal_op
  logic [14:0] obs;
  assign obs = {mem_if.MemRead, mem_if.MemWrite, mem_if.IorD, IRWrite, MDRWrite,
                PCWrite, PCSrc, ABWrite, ALUSrcB, AluOutWrite, RegWrite, RegDst,
                MemToReg, illegal_op};

  localparam logic [14:0] O_ZERO   = 15'b0_0_0_0_0_0_00_0_0_0_0_0_0_0;
  localparam logic [14:0] F_RDY    = 15'b1_0_0_1_0_1_00_0_0_0_0_0_0_0;
  localparam logic [14:0] F_WAIT   = 15'b1_0_0_0_0_0_00_0_0_0_0_0_0_0;
  localparam logic [14:0] DEC      = 15'b0_0_0_0_0_0_00_1_0_0_0_0_0_0;
  localparam logic [14:0] DEC_ILL  = 15'b0_0_0_0_0_0_00_1_0_0_0_0_0_1;
  localparam logic [14:0] EXC      = 15'b0_0_0_0_0_0_00_0_0_1_0_0_0_0;
  localparam logic [14:0] EXI      = 15'b0_0_0_0_0_0_00_0_1_1_0_0_0_0;
  localparam logic [14:0] WB_R0    = 15'b0_0_0_0_0_0_00_0_0_0_1_0_0_0;
  localparam logic [14:0] WB_RI    = 15'b0_0_0_0_0_0_00_0_0_0_1_1_0_0;
  localparam logic [14:0] WB_LDV   = 15'b0_0_0_0_0_0_00_0_0_0_1_0_1_0;
  localparam logic [14:0] MRD_RDY  = 15'b1_0_1_0_1_0_00_0_0_0_0_0_0_0;
  localparam logic [14:0] MRD_WAIT = 15'b1_0_1_0_0_0_00_0_0_0_0_0_0_0;
  localparam logic [14:0] MWR      = 15'b0_1_1_0_0_0_00_0_0_0_0_0_0_0;
  localparam logic [14:0] JMP      = 15'b0_0_0_0_0_1_01_0_0_0_0_0_0_0;
  localparam logic [14:0] BRZ_T    = 15'b0_0_0_0_0_1_10_0_0_0_0_0_0_0;
  localparam logic [14:0] BRZ_N    = 15'b0_0_0_0_0_0_10_0_0_0_0_0_0_0;

  typedef struct packed {
    logic [3:0]  op;
    logic        mv, nop, z, rdy;
    logic [3:0]  st;
    logic [14:0] o;
  } vec_t;

  task automatic test_reset();
    rst_n = 1'b1; Op = 4'h0; isMoveTo = 1'b0; isNop = 1'b0; Zero = 1'b0;
    mem_if.mem_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1; checks++;
    if (state !== S_RST || obs !== O_ZERO) begin
      errors++; $display("FAIL reset_assert state=%0d outs=%b required state=%0d outs=%b", state, obs, S_RST, O_ZERO);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1; checks++;
    if (state !== S_RST || obs !== O_ZERO) begin
      errors++; $display("FAIL reset_release state=%0d outs=%b required state=%0d outs=%b", state, obs, S_RST, O_ZERO);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_addi_moveto();
    vec_t tv [0:7];
    tv = '{'{4'hC, 1'b0, 1'b0, 1'b0, 1'b1, S_FETCH,  F_RDY},
           '{4'hC, 1'b0, 1'b0, 1'b0, 1'b1, S_DECODE, DEC},
           '{4'hC, 1'b0, 1'b0, 1'b0, 1'b1, S_EXE_I,  EXI},
           '{4'hC, 1'b0, 1'b0, 1'b0, 1'b1, S_WB_I,   WB_R0},
           '{4'h8, 1'b1, 1'b0, 1'b0, 1'b1, S_FETCH,  F_RDY},
           '{4'h8, 1'b1, 1'b0, 1'b0, 1'b1, S_DECODE, DEC},
           '{4'h8, 1'b1, 1'b0, 1'b0, 1'b1, S_EXE_C,  EXC},
           '{4'h8, 1'b1, 1'b0, 1'b0, 1'b1, S_WB_C,   WB_RI}};
    for (int i = 0; i < 8; i++) begin
      {Op, isMoveTo, isNop, Zero, mem_if.mem_ready} = {tv[i].op, tv[i].mv, tv[i].nop, tv[i].z, tv[i].rdy};
      #1; checks++;
      if (state !== tv[i].st || obs !== tv[i].o) begin
        errors++; $display("FAIL addi_moveto[%0d] state=%0d outs=%b required state=%0d outs=%b", i, state, obs, tv[i].st, tv[i].o);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_wait();
    vec_t tv [0:8];
    tv = '{'{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, S_FETCH,  F_WAIT},
           '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, S_FETCH,  F_WAIT},
           '{4'h0, 1'b0, 1'b0, 1'b0, 1'b1, S_FETCH,  F_RDY},
           '{4'h0, 1'b0, 1'b0, 1'b0, 1'b1, S_DECODE, DEC},
           '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, S_MEM_RD, MRD_WAIT},
           '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, S_MEM_RD, MRD_WAIT},
           '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, S_MEM_RD, MRD_WAIT},
           '{4'h0, 1'b0, 1'b0, 1'b0, 1'b1, S_MEM_RD, MRD_RDY},
           '{4'h0, 1'b0, 1'b0, 1'b0, 1'b1, S_WB_LD,  WB_LDV}};
    for (int i = 0; i < 9; i++) begin
      {Op, isMoveTo, isNop, Zero, mem_if.mem_ready} = {tv[i].op, tv[i].mv, tv[i].nop, tv[i].z, tv[i].rdy};
      #1; checks++;
      if (state !== tv[i].st || obs !== tv[i].o) begin
        errors++; $display("FAIL load_wait[%0d] state=%0d outs=%b required state=%0d outs=%b", i, state, obs, tv[i].st, tv[i].o);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    vec_t tv [0:5];
    tv = '{'{4'h4, 1'b0, 1'b0, 1'b1, 1'b1, S_FETCH,  F_RDY},
           '{4'h4, 1'b0, 1'b0, 1'b1, 1'b1, S_DECODE, DEC},
           '{4'h4, 1'b0, 1'b0, 1'b1, 1'b1, S_BRZ,    BRZ_T},
           '{4'h4, 1'b0, 1'b0, 1'b0, 1'b1, S_FETCH,  F_RDY},
           '{4'h4, 1'b0, 1'b0, 1'b0, 1'b1, S_DECODE, DEC},
           '{4'h4, 1'b0, 1'b0, 1'b0, 1'b1, S_BRZ,    BRZ_N}};
    for (int i = 0; i < 6; i++) begin
      {Op, isMoveTo, isNop, Zero, mem_if.mem_ready} = {tv[i].op, tv[i].mv, tv[i].nop, tv[i].z, tv[i].rdy};
      #1; checks++;
      if (state !== tv[i].st || obs !== tv[i].o) begin
        errors++; $display("FAIL branch[%0d] state=%0d outs=%b required state=%0d outs=%b", i, state, obs, tv[i].st, tv[i].o);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_nop_illegal();
    vec_t tv [0:3];
    tv = '{'{4'h8, 1'b0, 1'b1, 1'b0, 1'b1, S_FETCH,  F_RDY},
           '{4'h8, 1'b0, 1'b1, 1'b0, 1'b1, S_DECODE, DEC},
           '{4'h7, 1'b0, 1'b0, 1'b0, 1'b1, S_FETCH,  F_RDY},
           '{4'h7, 1'b0, 1'b0, 1'b0, 1'b1, S_DECODE, DEC_ILL}};
    for (int i = 0; i < 4; i++) begin
      {Op, isMoveTo, isNop, Zero, mem_if.mem_ready} = {tv[i].op, tv[i].mv, tv[i].nop, tv[i].z, tv[i].rdy};
      #1; checks++;
      if (state !== tv[i].st || obs !== tv[i].o) begin
        errors++; $display("FAIL nop_illegal[%0d] state=%0d outs=%b required state=%0d outs=%b", i, state, obs, tv[i].st, tv[i].o);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jump();
    vec_t tv [0:3];
    tv = '{'{4'h2, 1'b0, 1'b0, 1'b0, 1'b1, S_FETCH,  F_RDY},
           '{4'h2, 1'b0, 1'b0, 1'b0, 1'b1, S_DECODE, DEC},
           '{4'h2, 1'b0, 1'b0, 1'b0, 1'b1, S_JUMP,   JMP},
           '{4'h2, 1'b0, 1'b0, 1'b0, 1'b0, S_FETCH,  F_WAIT}};
    for (int i = 0; i < 4; i++) begin
      {Op, isMoveTo, isNop, Zero, mem_if.mem_ready} = {tv[i].op, tv[i].mv, tv[i].nop, tv[i].z, tv[i].rdy};
      #1; checks++;
      if (state !== tv[i].st || obs !== tv[i].o) begin
        errors++; $display("FAIL jump[%0d] state=%0d outs=%b required state=%0d outs=%b", i, state, obs, tv[i].st, tv[i].o);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store_reset();
    vec_t tv [0:6];
    tv = '{'{4'h1, 1'b0, 1'b0, 1'b0, 1'b1, S_FETCH,  F_RDY},
           '{4'h1, 1'b0, 1'b0, 1'b0, 1'b1, S_DECODE, DEC},
           '{4'h1, 1'b0, 1'b0, 1'b0, 1'b1, S_MEM_WR, MWR},
           '{4'h1, 1'b0, 1'b0, 1'b0, 1'b1, S_FETCH,  F_RDY},
           '{4'h1, 1'b0, 1'b0, 1'b0, 1'b1, S_DECODE, DEC},
           '{4'h1, 1'b0, 1'b0, 1'b0, 1'b0, S_MEM_WR, MWR},
           '{4'h1, 1'b0, 1'b0, 1'b0, 1'b0, S_MEM_WR, MWR}};
    for (int i = 0; i < 7; i++) begin
      {Op, isMoveTo, isNop, Zero, mem_if.mem_ready} = {tv[i].op, tv[i].mv, tv[i].nop, tv[i].z, tv[i].rdy};
      #1; checks++;
      if (state !== tv[i].st || obs !== tv[i].o) begin
        errors++; $display("FAIL store[%0d] state=%0d outs=%b required state=%0d outs=%b", i, state, obs, tv[i].st, tv[i].o);
      end
      @(posedge clk); #1;
    end
    // Still waiting in MEM_WR; reset lands mid-cycle
    #1; checks++;
    if (state !== S_MEM_WR || obs !== MWR) begin
      errors++; $display("FAIL store_hold state=%0d outs=%b required state=%0d outs=%b", state, obs, S_MEM_WR, MWR);
    end
    #1 rst_n = 1'b0;
    #1; checks++;
    if (state !== S_RST || obs !== O_ZERO) begin
      errors++; $display("FAIL store_reset state=%0d outs=%b required state=%0d outs=%b", state, obs, S_RST, O_ZERO);
    end
    @(negedge clk); rst_n = 1'b1;
    #1; checks++;
    if (state !== S_RST || obs !== O_ZERO) begin
      errors++; $display("FAIL store_release state=%0d outs=%b required state=%0d outs=%b", state, obs, S_RST, O_ZERO);
    end
    @(posedge clk); #1; checks++;
    if (state !== S_FETCH || obs !== F_WAIT) begin
      errors++; $display("FAIL store_refetch state=%0d outs=%b required state=%0d outs=%b", state, obs, S_FETCH, F_WAIT);
    end
  endtask

  initial begin
    test_reset();
    test_addi_moveto();
    test_load_wait();
    test_branch();
    test_nop_illegal();
    mem_if.mem_ready = 1'b1;
    test_jump();
    // leave FETCH through the wait row of test_jump with a completed read
    mem_if.mem_ready = 1'b1;
    test_store_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
